// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate / branch / jump operand generator.
// Sits between instruction-register decode and the ALU B-operand and PC-source
// muxes. Each accepted request produces one result on a registered output
// stage. A one-entry skid buffer lets downstream stall without a combinational
// ready path back to the decoder.
//
// Ports:
//   clk, reset_n          rising-edge clock, async active-low reset
//   in_valid / in_ready   request handshake (in_ready is registered: skid empty)
//   mode                  000 ZE, 001 SE, 010 LUI, 011 BOFF, 100 JMP,
//                         101 SHAMT, 110 BTGT, 111 illegal
//   imm_in, jidx_in       instruction immediate and jump index fields
//   pc_in                 PC+4 of the instruction
//   out_valid / out_ready result handshake
//   imm_out, illegal_out  generated value, illegal-mode flag
//   illegal_cnt           saturating count of accepted illegal requests
module imm_gen_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned JIDX_WIDTH = 26,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            mode,
  input  logic [IMM_WIDTH-1:0]  imm_in,
  input  logic [JIDX_WIDTH-1:0] jidx_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] imm_out,
  output logic                  illegal_out,
  output logic [CNT_WIDTH-1:0]  illegal_cnt
);

  localparam int unsigned EXT_WIDTH = DATA_WIDTH - IMM_WIDTH;

  localparam logic [2:0] MODE_ZE      = 3'd0;
  localparam logic [2:0] MODE_SE      = 3'd1;
  localparam logic [2:0] MODE_LUI     = 3'd2;
  localparam logic [2:0] MODE_BOFF    = 3'd3;
  localparam logic [2:0] MODE_JMP     = 3'd4;
  localparam logic [2:0] MODE_SHAMT   = 3'd5;
  localparam logic [2:0] MODE_BTGT    = 3'd6;
  localparam logic [2:0] MODE_ILLEGAL = 3'd7;

  // Elaboration-time parameter legality
  if (DATA_WIDTH < 16 || DATA_WIDTH > 64) begin : gBadDataWidth
    $error("imm_gen_pipe: DATA_WIDTH must be 16..64");
  end
  if (IMM_WIDTH < 11 || IMM_WIDTH > DATA_WIDTH - 2) begin : gBadImmWidth
    $error("imm_gen_pipe: IMM_WIDTH must be 11..DATA_WIDTH-2");
  end
  if (JIDX_WIDTH != DATA_WIDTH - 6) begin : gBadJidxWidth
    $error("imm_gen_pipe: JIDX_WIDTH must equal DATA_WIDTH-6");
  end
  if (CNT_WIDTH < 1) begin : gBadCntWidth
    $error("imm_gen_pipe: CNT_WIDTH must be at least 1");
  end

  typedef struct packed {
    logic                  illegal;
    logic [DATA_WIDTH-1:0] value;
  } resultT;

  logic [DATA_WIDTH-1:0] seImm;
  logic [DATA_WIDTH-1:0] boffImm;
  resultT                newResult;

  // Operand generation for the incoming request
  always_comb begin
    seImm     = {{EXT_WIDTH{imm_in[IMM_WIDTH-1]}}, imm_in};
    boffImm   = seImm << 2;
    newResult = '0;
    unique case (mode)
      MODE_ZE:    newResult.value = DATA_WIDTH'(imm_in);
      MODE_SE:    newResult.value = seImm;
      MODE_LUI:   newResult.value = {imm_in, {EXT_WIDTH{1'b0}}};
      MODE_BOFF:  newResult.value = boffImm;
      MODE_JMP:   newResult.value = {pc_in[DATA_WIDTH-1:DATA_WIDTH-4], jidx_in, 2'b00};
      MODE_SHAMT: newResult.value = DATA_WIDTH'(imm_in[10:6]);
      MODE_BTGT:  newResult.value = pc_in + boffImm;
      default:    newResult.illegal = 1'b1;
    endcase
  end

  logic                 inReadyQ;
  logic                 outValidQ, outValidD;
  resultT               outDataQ, outDataD;
  logic                 skidValidQ, skidValidD;
  resultT               skidDataQ, skidDataD;
  logic [CNT_WIDTH-1:0] illegalCntQ, illegalCntD;
  logic                 accept;
  logic                 drain;

  // Output register / skid next-state. Acceptance implies the skid is empty,
  // so a full skid never has to absorb a new request in the same cycle.
  always_comb begin
    accept      = in_valid & inReadyQ;
    drain       = outValidQ & out_ready;
    outValidD   = outValidQ;
    outDataD    = outDataQ;
    skidValidD  = skidValidQ;
    skidDataD   = skidDataQ;
    illegalCntD = illegalCntQ;

    if (!outValidQ || drain) begin
      if (skidValidQ) begin
        outDataD   = skidDataQ;
        outValidD  = 1'b1;
        skidValidD = 1'b0;
      end else if (accept) begin
        outDataD  = newResult;
        outValidD = 1'b1;
      end else begin
        outValidD = 1'b0;
      end
    end else if (accept) begin
      skidDataD  = newResult;
      skidValidD = 1'b1;
    end

    if (accept && mode == MODE_ILLEGAL && illegalCntQ != '1) begin
      illegalCntD = illegalCntQ + CNT_WIDTH'(1);
    end
  end

  // State registers; in_ready tracks the next skid occupancy so it stays
  // registered and low throughout reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inReadyQ    <= 1'b0;
      outValidQ   <= 1'b0;
      outDataQ    <= '0;
      skidValidQ  <= 1'b0;
      skidDataQ   <= '0;
      illegalCntQ <= '0;
    end else begin
      inReadyQ    <= ~skidValidD;
      outValidQ   <= outValidD;
      outDataQ    <= outDataD;
      skidValidQ  <= skidValidD;
      skidDataQ   <= skidDataD;
      illegalCntQ <= illegalCntD;
    end
  end

  assign in_ready    = inReadyQ;
  assign out_valid   = outValidQ;
  assign imm_out     = outDataQ.value;
  assign illegal_out = outDataQ.illegal;
  assign illegal_cnt = illegalCntQ;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe.
// uDut (default widths) and uCnt2 (CNT_WIDTH=2) share stimulus; uWide is the
// 64-bit instance. Drivers push expected results, monitors pop and compare.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inValid, outReady;
  logic [2:0]  mode;
  logic [15:0] imm;
  logic [25:0] jidx;
  logic [31:0] pc;
  logic        inReady, outValid, illegalOut;
  logic [31:0] immOut;
  logic [7:0]  illegalCnt;

  logic        c2InReady, c2Valid, c2Ill;
  logic [31:0] c2ImmOut;
  logic [1:0]  c2Cnt;

  logic        inValidW, outReadyW;
  logic [2:0]  modeW;
  logic [15:0] immW;
  logic [57:0] jidxW;
  logic [63:0] pcW;
  logic        inReadyW, outValidW, illegalOutW;
  logic [63:0] immOutW;
  logic [7:0]  illegalCntW;

  always #5 clk = ~clk;

  imm_gen_pipe uDut (
    .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady),
    .mode(mode), .imm_in(imm), .jidx_in(jidx), .pc_in(pc),
    .out_valid(outValid), .out_ready(outReady), .imm_out(immOut),
    .illegal_out(illegalOut), .illegal_cnt(illegalCnt)
  );

  imm_gen_pipe #(.CNT_WIDTH(2)) uCnt2 (
    .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(c2InReady),
    .mode(mode), .imm_in(imm), .jidx_in(jidx), .pc_in(pc),
    .out_valid(c2Valid), .out_ready(outReady), .imm_out(c2ImmOut),
    .illegal_out(c2Ill), .illegal_cnt(c2Cnt)
  );

  imm_gen_pipe #(.DATA_WIDTH(64), .IMM_WIDTH(16), .JIDX_WIDTH(58)) uWide (
    .clk(clk), .reset_n(reset_n), .in_valid(inValidW), .in_ready(inReadyW),
    .mode(modeW), .imm_in(immW), .jidx_in(jidxW), .pc_in(pcW),
    .out_valid(outValidW), .out_ready(outReadyW), .imm_out(immOutW),
    .illegal_out(illegalOutW), .illegal_cnt(illegalCntW)
  );

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    int          acc;
    bit          chkLat;
  } expT;

  expT q[$];
  expT qW[$];
  expT mt, mtW;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Drive one request on uDut/uCnt2; expected value is queued once acceptance is certain
  task automatic send(input logic [2:0] m, input logic [15:0] im, input logic [25:0] j,
                      input logic [31:0] p, input logic [31:0] e, input logic il, input bit c);
    expT t;
    @(negedge clk);
    inValid = 1'b1; mode = m; imm = im; jidx = j; pc = p;
    for (int k = 0; k < 100 && !inReady; k++) @(negedge clk);
    if (!inReady) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      t.imm = 64'(e); t.ill = il; t.acc = cyc + 1; t.chkLat = c;
      q.push_back(t);
    end
  endtask

  task automatic sendW(input logic [2:0] m, input logic [15:0] im, input logic [57:0] j,
                       input logic [63:0] p, input logic [63:0] e);
    expT t;
    @(negedge clk);
    inValidW = 1'b1; modeW = m; immW = im; jidxW = j; pcW = p;
    for (int k = 0; k < 100 && !inReadyW; k++) @(negedge clk);
    if (!inReadyW) begin
      checks++; failures++;
      $display("FAIL sendw_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      t.imm = e; t.ill = 1'b0; t.acc = cyc + 1; t.chkLat = 1'b1;
      qW.push_back(t);
    end
  endtask

  // Main-instance monitor: result compare, latency and hold-while-stalled
  bit          stallPrev = 1'b0;
  logic [31:0] holdImm;
  logic        holdIll;

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (stallPrev) begin
        chk("hold_valid", 64'(outValid), 64'(1));
        chk("hold_imm", 64'(immOut), 64'(holdImm));
        chk("hold_illegal", 64'(illegalOut), 64'(holdIll));
      end
      if (outValid && outReady) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%h required=no_output", immOut);
        end else begin
          mt = q.pop_front();
          chk("imm_out", 64'(immOut), mt.imm);
          chk("illegal_out", 64'(illegalOut), 64'(mt.ill));
          chk("cnt2_valid", 64'(c2Valid), 64'(1));
          chk("cnt2_imm_out", 64'(c2ImmOut), mt.imm);
          chk("cnt2_illegal_out", 64'(c2Ill), 64'(mt.ill));
          if (mt.chkLat) chk("latency_cycle", 64'(cyc), 64'(mt.acc));
        end
      end
      stallPrev = outValid && !outReady;
      holdImm   = immOut;
      holdIll   = illegalOut;
    end else begin
      stallPrev = 1'b0;
    end
  end

  always @(negedge clk) begin
    #1;
    if (reset_n && outValidW && outReadyW) begin
      if (qW.size() == 0) begin
        checks++; failures++;
        $display("FAIL wide_unexpected_output actual=%h required=no_output", immOutW);
      end else begin
        mtW = qW.pop_front();
        chk("wide_imm_out", immOutW, mtW.imm);
        chk("wide_illegal_out", 64'(illegalOutW), 64'(mtW.ill));
        chk("wide_latency", 64'(cyc), 64'(mtW.acc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    mode = 3'd0; imm = '0; jidx = '0; pc = '0;
    inValidW = 1'b0; outReadyW = 1'b1; modeW = 3'd0; immW = '0; jidxW = '0; pcW = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(outValid), 64'(0));
    chk("rst_imm_out", 64'(immOut), 64'(0));
    chk("rst_illegal_out", 64'(illegalOut), 64'(0));
    chk("rst_illegal_cnt", 64'(illegalCnt), 64'(0));
    chk("rst_in_ready", 64'(inReady), 64'(0));
    chk("rst_cnt2_in_ready", 64'(c2InReady), 64'(0));
    reset_n = 1'b1;
    chk("in_ready_before_edge", 64'(inReady), 64'(0));
    @(negedge clk);
    chk("in_ready_after_edge", 64'(inReady), 64'(1));

    // All modes, back-to-back, no backpressure
    send(3'd0, 16'h8004, 26'h0, 32'h0040_0010, 32'h0000_8004, 1'b0, 1'b1);
    send(3'd1, 16'h8004, 26'h0, 32'h0040_0010, 32'hFFFF_8004, 1'b0, 1'b1);
    send(3'd2, 16'h8004, 26'h0, 32'h0040_0010, 32'h8004_0000, 1'b0, 1'b1);
    send(3'd3, 16'h8004, 26'h0, 32'h0040_0010, 32'hFFFE_0010, 1'b0, 1'b1);
    send(3'd6, 16'h8004, 26'h0, 32'h0040_0010, 32'h003E_0020, 1'b0, 1'b1);
    send(3'd5, 16'h8004, 26'h0, 32'h0040_0010, 32'h0000_0000, 1'b0, 1'b1);
    send(3'd5, 16'h07C0, 26'h0, 32'h0040_0010, 32'h0000_001F, 1'b0, 1'b1);
    send(3'd4, 16'h0000, 26'h3FF_FFFF, 32'hA000_0000, 32'hAFFF_FFFC, 1'b0, 1'b1);
    send(3'd1, 16'h1234, 26'h0, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
    send(3'd6, 16'h0008, 26'h0, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 1'b1);
    @(negedge clk); inValid = 1'b0;
    repeat (3) @(negedge clk);

    // Illegal mode and counter saturation
    send(3'd7, 16'hFFFF, 26'h155_5555, 32'h1234_5678, 32'h0, 1'b1, 1'b1);
    send(3'd7, 16'h8004, 26'h0, 32'h0040_0010, 32'h0, 1'b1, 1'b1);
    send(3'd7, 16'h0001, 26'h1, 32'h1, 32'h0, 1'b1, 1'b1);
    @(negedge clk); inValid = 1'b0;
    repeat (2) @(negedge clk);
    chk("illegal_cnt_3", 64'(illegalCnt), 64'(3));
    chk("cnt2_illegal_cnt_3", 64'(c2Cnt), 64'(3));
    send(3'd7, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    send(3'd7, 16'h0, 26'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk); inValid = 1'b0;
    repeat (2) @(negedge clk);
    chk("illegal_cnt_5", 64'(illegalCnt), 64'(5));
    chk("cnt2_illegal_cnt_sat", 64'(c2Cnt), 64'(3));

    // Backpressure: A held, B in skid, C stalled until drain
    outReady = 1'b0;
    fork
      begin
        send(3'd0, 16'h0001, 26'h0, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        send(3'd1, 16'hFFFE, 26'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send(3'd2, 16'h00AB, 26'h0, 32'h0, 32'h00AB_0000, 1'b0, 1'b0);
        @(negedge clk); inValid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_drop", 64'(inReady), 64'(0));
        chk("bp_out_valid", 64'(outValid), 64'(1));
        chk("bp_hold_a", 64'(immOut), 64'(32'h0000_0001));
        repeat (2) @(negedge clk);
        chk("bp_c_stalled", 64'(inReady), 64'(0));
        chk("bp_still_a", 64'(immOut), 64'(32'h0000_0001));
        outReady = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("bp_drained", 64'(q.size()), 64'(0));

    // Reset pulse with output and skid both full
    outReady = 1'b0;
    send(3'd0, 16'h0055, 26'h0, 32'h0, 32'h0000_0055, 1'b0, 1'b0);
    send(3'd0, 16'h0066, 26'h0, 32'h0, 32'h0000_0066, 1'b0, 1'b0);
    @(negedge clk); inValid = 1'b0;
    chk("pre_rst_skid_full", 64'(inReady), 64'(0));
    #2;
    reset_n = 1'b0;
    q.delete();
    stallPrev = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(outValid), 64'(0));
    chk("midrst_in_ready", 64'(inReady), 64'(0));
    chk("midrst_illegal_cnt", 64'(illegalCnt), 64'(0));
    chk("midrst_cnt2_cnt", 64'(c2Cnt), 64'(0));
    #1;
    reset_n = 1'b1;
    chk("midrst_release_in_ready", 64'(inReady), 64'(0));
    @(negedge clk);
    chk("midrst_edge_in_ready", 64'(inReady), 64'(1));
    chk("midrst_edge_out_valid", 64'(outValid), 64'(0));
    outReady = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_stale", 64'(outValid), 64'(0));

    // 64-bit instance
    sendW(3'd1, 16'hFFFF, 58'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    sendW(3'd2, 16'h1234, 58'h0, 64'h0, 64'h1234_0000_0000_0000);
    sendW(3'd0, 16'h8004, 58'h0, 64'h0, 64'h0000_0000_0000_8004);
    sendW(3'd4, 16'h0000, 58'h3FF_FFFF_FFFF_FFFF, 64'hA000_0000_0000_0000, 64'hAFFF_FFFF_FFFF_FFFC);
    @(negedge clk); inValidW = 1'b0;

    for (int k = 0; k < 50 && (q.size() != 0 || qW.size() != 0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'(0));
    chk("wide_sb_empty", 64'(qW.size()), 64'(0));
    chk("wide_illegal_cnt", 64'(illegalCntW), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the multicycle datapath.
- Supersedes the combinational extender: ZE/SE/LUI plus branch offset, PC-relative branch target, jump target and shift-amount modes.
- Delivers results through a valid/ready handshake with a registered output and a one-entry skid buffer, so the decode/ALU stages can stall it.
- Sits between instruction register decode and the ALU B-operand / PC-source muxes.

Parameters:
- DATA_WIDTH, 32, width of generated operand and PC; legal range is 16 to 64.
- IMM_WIDTH, 16, width of the instruction immediate field; must be at least 11 and at most DATA_WIDTH-2.
- JIDX_WIDTH, 26, jump index width; must equal DATA_WIDTH-6.
- CNT_WIDTH, 8, width of the illegal-mode event counter.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request this cycle
- mode  input  3  operation select (see Behaviour)
- imm_in  input  IMM_WIDTH  immediate field
- jidx_in  input  JIDX_WIDTH  jump index field
- pc_in  input  DATA_WIDTH  PC+4 of the instruction
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- imm_out  output  DATA_WIDTH  generated value
- illegal_out  output  1  result came from an illegal mode
- illegal_cnt  output  CNT_WIDTH  saturating count of accepted illegal requests

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (reset_n).
  - While reset_n=0: out_valid=0, imm_out=0, illegal_out=0, illegal_cnt=0, skid empty, in_ready=0.
  - in_ready=1 from the first clock edge after reset_n rises.
  - A reset asserted mid-operation discards the output register and skid contents immediately.
- Modes (SE = sign-extend imm_in to DATA_WIDTH, all arithmetic modulo 2^DATA_WIDTH):
  - 000 ZE: zero-extend imm_in.
  - 001 SE: SE.
  - 010 LUI: {imm_in, (DATA_WIDTH-IMM_WIDTH) zeros}.
  - 011 BOFF: SE<<2; upper bits shifted out are dropped.
  - 100 JMP: {pc_in[DATA_WIDTH-1:DATA_WIDTH-4], jidx_in, 2'b00}.
  - 101 SHAMT: zero-extend imm_in[10:6].
  - 110 BTGT: pc_in + (SE<<2); carry out is discarded.
  - 111 illegal: imm_out=0, illegal_out=1.
- Handshake:
  - A transfer occurs on a cycle with in_valid&in_ready (input side) or out_valid&out_ready (output side).
  - Latency: an accepted input appears on imm_out/out_valid the next cycle if the output register is empty or is draining that cycle.
  - Otherwise the accepted input enters the skid entry.
  - in_ready = skid empty. It is registered and never depends combinationally on out_ready.
  - On an output transfer with the skid full, the skid entry moves to the output register and the skid empties.
  - Simultaneous input accept and output drain with the skid empty: the new result replaces the output register; out_valid stays 1.
  - Order is strictly preserved; there is never any loss or duplication.
  - imm_out/illegal_out are held stable while out_valid=1 and out_ready=0.
  - Inputs are ignored when in_valid&in_ready is false.
- illegal_cnt:
  - Increments by 1 on each accepted request with mode=111.
  - Saturates at 2^CNT_WIDTH-1.
  - Cleared only by reset.

Test Plan:
- Modes, out_ready=1, imm_in=16'h8004, pc_in=32'h0040_0010:
  - ZE gives 0000_8004.
  - SE gives FFFF_8004.
  - LUI gives 8004_0000.
  - BOFF gives FFFE_0010.
  - BTGT gives 003E_0020.
  - SHAMT gives 0000_0000; with imm_in=16'h07C0 it gives 0000_001F.
  - Each result appears exactly 1 cycle after acceptance.
- JMP, pc_in=32'hA000_0000, jidx_in=26'h3FF_FFFF: result AFFF_FFFC.
- Backpressure:
  - Send 3 back-to-back requests A, B, C with out_ready=0.
  - Required: A is held on the output and B is in the skid.
  - in_ready drops the cycle after B is accepted, and C is stalled.
  - Raise out_ready: outputs A, B, C appear in order with no gaps beyond 1 cycle and no duplicates.
- Illegal mode:
  - 3 accepted requests with mode=111: each has imm_out=0 and illegal_out=1; illegal_cnt=3.
  - With CNT_WIDTH=2, 5 illegal requests leave illegal_cnt saturated at 3.
- Reset mid-stall:
  - With the output and skid full, pulse reset_n low between clock edges.
  - Required: out_valid=0 and in_ready=0 immediately; in_ready=1 one edge after release.
  - No stale result is emitted afterwards.
- Parameter sweep: DATA_WIDTH=64, IMM_WIDTH=16, JIDX_WIDTH=58: SE of 16'hFFFF gives 64'hFFFF_FFFF_FFFF_FFFF; LUI of 16'h1234 gives 64'h1234_0000_0000_0000.
